// File: rtl/serial_tx_if.sv
// serial_tx_if: load/payload request and serial-line status bundle for serial_tx.
// The master drives din/load; the slave (serial_tx) returns ready, sout, busy and done.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              load;
    logic              ready;
    logic              sout;
    logic              busy;
    logic              done;

    modport master (
        output din,
        output load,
        input  ready,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: parallel-load, LSB-first serial transmitter.
// Frame: START (0), DATA_W data bits, optional even-parity bit, STOP (1).
// Define SERIAL_TX_PARITY_EN to insert the parity bit between DATA and STOP.
// Every output is a register updated with the state transition, so all of
// them line up with the state they describe and are glitch-free.
module serial_tx #(
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        clear,
    serial_tx_if.slave  bus
);
    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sout;
    logic                r_busy;
    logic                r_ready;
    logic                r_done;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity;
`endif

    // A load is only honoured when ready is already high at the edge; ready is
    // held low during clear and for the first cycle after it, so a load that
    // coincides with the reset release is not taken.
    logic w_accept;
    assign w_accept = bus.load & r_ready;

    // Frame sequencer: state, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_sout   <= 1'b1;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                // IDLE and STOP both accept a new payload; taking it from STOP
                // starts the next frame with no idle gap.
                S_IDLE, S_STOP: begin
                    if (w_accept) begin
                        r_shift  <= bus.din;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= ^bus.din;
`endif
                        r_cnt    <= '0;
                        r_state  <= S_START;
                        r_sout   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_done   <= 1'b0;
                    end else begin
                        r_state  <= S_IDLE;
                        r_sout   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                // The LSB is presented as DATA is entered, so DATA holds bit 0
                // while the counter reads 0.
                S_START: begin
                    r_state <= S_DATA;
                    r_sout  <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
                S_DATA: begin
                    if (r_cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        r_state <= S_PAR;
                        r_sout  <= r_parity;
`else
                        r_state <= S_STOP;
                        r_sout  <= 1'b1;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_sout  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PAR: begin
                    r_state <= S_STOP;
                    r_sout  <= 1'b1;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_sout  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sout  = r_sout;
    assign bus.busy  = r_busy;
    assign bus.ready = r_ready;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx (DATA_W=8 and DATA_W=2 instances).
// Expected sout sequences follow SERIAL_TX_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_serial_tx;
    logic clk;
    logic clear;
    int   checks;
    int   failures;

    serial_tx_if #(.DATA_W(8)) bus  ();
    serial_tx_if #(.DATA_W(2)) bus2 ();

    serial_tx #(.DATA_W(8)) u_dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    serial_tx #(.DATA_W(2)) u_dut2 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear     = 1'b1;
        bus.load  = 1'b0;
        bus.din   = '0;
        bus2.load = 1'b0;
        bus2.din  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.sout !== 1'b1)  begin failures++; $display("FAIL reset_sout: got %b expected 1", bus.sout); end
        checks++;
        if (bus.busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        clear = 1'b0;
        tick();
        checks++;
        if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", bus.ready); end
        checks++;
        if (bus2.ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready_w2: got %b expected 1", bus2.ready); end
        $display("test_reset done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_single_frame();
        int exp_q[$];
`ifdef SERIAL_TX_PARITY_EN
        exp_q = '{0, 1,0,1,0,0,1,0,1, 0, 1};
`else
        exp_q = '{0, 1,0,1,0,0,1,0,1, 1};
`endif
        bus.din  = 8'hA5;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.sout !== exp_q[i][0]) begin
                failures++; $display("FAIL single_sout[%0d]: got %b expected %0d", i, bus.sout, exp_q[i]);
            end
            checks++;
            if (bus.done !== (i == exp_q.size() - 1)) begin
                failures++; $display("FAIL single_done[%0d]: got %b expected %0d", i, bus.done, (i == exp_q.size() - 1));
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++; $display("FAIL single_busy[%0d]: got %b expected 1", i, bus.busy);
            end
            tick();
        end
        checks++;
        if ({bus.sout, bus.busy, bus.done, bus.ready} !== 4'b1001) begin
            failures++; $display("FAIL single_idle: got sout/busy/done/ready=%b expected 1001",
                                 {bus.sout, bus.busy, bus.done, bus.ready});
        end
        $display("test_single_frame A5 done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        int flen;
`ifdef SERIAL_TX_PARITY_EN
        exp_q = '{0, 0,0,0,0,0,0,0,0, 0, 1,  0, 1,1,1,1,1,1,1,1, 0, 1};
        flen  = 11;
`else
        exp_q = '{0, 0,0,0,0,0,0,0,0, 1,  0, 1,1,1,1,1,1,1,1, 1};
        flen  = 10;
`endif
        bus.din  = 8'h00;
        bus.load = 1'b1;
        tick();
        bus.din  = 8'hFF;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.sout !== exp_q[i][0]) begin
                failures++; $display("FAIL b2b_sout[%0d]: got %b expected %0d", i, bus.sout, exp_q[i]);
            end
            checks++;
            if (bus.done !== ((i == flen - 1) || (i == 2 * flen - 1))) begin
                failures++; $display("FAIL b2b_done[%0d]: got %b expected %0d", i, bus.done,
                                     ((i == flen - 1) || (i == 2 * flen - 1)));
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++; $display("FAIL b2b_busy[%0d]: got %b expected 1", i, bus.busy);
            end
            if (i == flen) bus.load = 1'b0;
            tick();
        end
        checks++;
        if ({bus.sout, bus.busy} !== 2'b10) begin
            failures++; $display("FAIL b2b_idle: got sout/busy=%b expected 10", {bus.sout, bus.busy});
        end
        $display("test_back_to_back 00/FF done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_ignored_load();
        int exp_q[$];
`ifdef SERIAL_TX_PARITY_EN
        exp_q = '{0, 1,0,0,0,0,0,0,1, 0, 1};
`else
        exp_q = '{0, 1,0,0,0,0,0,0,1, 1};
`endif
        bus.din  = 8'h81;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.sout !== exp_q[i][0]) begin
                failures++; $display("FAIL ignored_sout[%0d]: got %b expected %0d", i, bus.sout, exp_q[i]);
            end
            if (i == 3) begin
                bus.din  = 8'h3C;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.sout, bus.busy} !== 2'b10) begin
                failures++; $display("FAIL ignored_no_extra[%0d]: got sout/busy=%b expected 10", i, {bus.sout, bus.busy});
            end
            tick();
        end
        $display("test_ignored_load 81/3C done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_clear_mid_frame();
        bus.din  = 8'h00;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.sout, bus.busy} !== 2'b01) begin
            failures++; $display("FAIL clear_pre_data: got sout/busy=%b expected 01", {bus.sout, bus.busy});
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if ({bus.sout, bus.busy, bus.done, bus.ready} !== 4'b1000) begin
            failures++; $display("FAIL clear_async: got sout/busy/done/ready=%b expected 1000",
                                 {bus.sout, bus.busy, bus.done, bus.ready});
        end
        tick();
        clear = 1'b0;
        tick();
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++; $display("FAIL clear_release_ready: got %b expected 1", bus.ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.sout, bus.busy} !== 2'b10) begin
                failures++; $display("FAIL clear_aborted[%0d]: got sout/busy=%b expected 10", i, {bus.sout, bus.busy});
            end
            tick();
        end
        $display("test_clear_mid_frame done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_width2();
        int exp_q[$];
`ifdef SERIAL_TX_PARITY_EN
        exp_q = '{0, 0, 1, 1, 1};
`else
        exp_q = '{0, 0, 1, 1};
`endif
        bus2.din  = 2'b10;
        bus2.load = 1'b1;
        tick();
        bus2.load = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus2.sout !== exp_q[i][0]) begin
                failures++; $display("FAIL w2_sout[%0d]: got %b expected %0d", i, bus2.sout, exp_q[i]);
            end
            checks++;
            if (bus2.done !== (i == exp_q.size() - 1)) begin
                failures++; $display("FAIL w2_done[%0d]: got %b expected %0d", i, bus2.done, (i == exp_q.size() - 1));
            end
            tick();
        end
        checks++;
        if ({bus2.sout, bus2.busy, bus2.ready} !== 3'b101) begin
            failures++; $display("FAIL w2_idle: got sout/busy/ready=%b expected 101", {bus2.sout, bus2.busy, bus2.ready});
        end
        $display("test_width2 din=10 done: checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_load();
        test_clear_mid_frame();
        test_width2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
